// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings for the memory arbiter
package mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LD  = 1'b1;

  localparam int WAIT_CYCLES_DEF = 2;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing main memory between CPU and loader
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_q, grant_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;

  logic cpu_req;
  logic pick_ld;

  assign cpu_req = cpu_rd | cpu_wr;
  // Loader wins when it is alone, or on a tie when the CPU was served last.
  assign pick_ld = ld_req & (~cpu_req | (last_grant_q == REQ_CPU));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    ld_rdata_d   = ld_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req || ld_req) begin
          grant_d      = pick_ld ? REQ_LD : REQ_CPU;
          last_grant_d = pick_ld ? REQ_LD : REQ_CPU;
          we_d         = pick_ld ? ld_we : cpu_wr;
          addr_d       = pick_ld ? ld_addr : cpu_addr;
          wdata_d      = pick_ld ? ld_wdata : cpu_wdata;
          cnt_d        = CNT_INIT;
          state_d      = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            if (grant_q == REQ_LD) ld_rdata_d = mem_rdata;
            else                   cpu_rdata_d = mem_rdata;
          end
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= REQ_LD;
      grant_q      <= REQ_CPU;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      ld_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ld_rdata_q   <= ld_rdata_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign mem_en    = (state_q == ST_ACCESS);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ld_rdata  = ld_rdata_q;
  assign cpu_ready = (state_q == ST_RESP) && (grant_q == REQ_CPU);
  assign ld_ready  = (state_q == ST_RESP) && (grant_q == REQ_LD);

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares the single-port main memory between the CPU multicycle controller and the program loader/debug port.
- Grants one access at a time with round-robin fairness.
- Drives the memory for a fixed number of wait cycles and returns read data with a one-cycle ready pulse to the granted requester.
- Sits between the CPU datapath's IorD address mux / memory-data register and the memory array.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- WAIT_CYCLES, 2, memory access latency in cycles; legal range 1..15

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- cpu_rd  in  1  CPU read request (level).
- cpu_wr  in  1  CPU write request (level).
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  CPU read data; registered.
- cpu_ready  out  1  one-cycle completion pulse to CPU.
- ld_req  in  1  loader request (level).
- ld_we  in  1  loader write when 1, read when 0.
- ld_addr  in  ADDR_W  loader address.
- ld_wdata  in  DATA_W  loader write data.
- ld_rdata  out  DATA_W  loader read data; registered.
- ld_ready  out  1  one-cycle completion pulse to loader.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high in any state other than IDLE.

## Operation
State machine IDLE -> ACCESS -> RESP -> IDLE.

IDLE:
- CPU request = cpu_rd | cpu_wr. Loader request = ld_req.
- One request pending: grant it.
- Both pending: grant the requester not in last_grant.
- On grant:
  - latch addr, wdata and we; for the CPU, we = cpu_wr.
  - cpu_rd & cpu_wr together is treated as a write.
  - last_grant <= granted requester.
  - wait counter <= WAIT_CYCLES-1.
  - go to ACCESS.
- No request: stay in IDLE.

ACCESS:
- mem_en=1, mem_we=latched we, mem_addr/mem_wdata = latched values, held constant for all ACCESS cycles.
- Counter decrements each cycle.
- At counter==0:
  - read: capture mem_rdata into the granted requester's rdata register.
  - go to RESP.

RESP:
- Granted requester's ready=1 for exactly this cycle.
- mem_en=0, mem_we=0.
- Next state IDLE.

Request rules:
- Request inputs are sampled only in IDLE.
- Changes to a request during ACCESS or RESP are ignored.
- A requester must hold its request until its ready pulse.
- A request still high in the IDLE cycle after RESP is a new request.

Output behaviour:
- Writes also pulse ready; the rdata register is unchanged on a write.
- rdata registers hold their value until the next read completion for that requester.
- The non-granted requester's ready stays 0 throughout.

## Timing
- Grant in IDLE at cycle 0; ACCESS occupies cycles 1..WAIT_CYCLES; ready and valid rdata at cycle WAIT_CYCLES+1; IDLE at WAIT_CYCLES+2.
- Back-to-back accesses from alternating requesters: one access per WAIT_CYCLES+2 cycles.
- Reset values:
  - state=IDLE; last_grant=LOADER, so the CPU wins the first tie.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_rdata=0, ld_rdata=0.
  - cpu_ready=0, ld_ready=0, busy=0.
- Reset during ACCESS or RESP:
  - next edge returns to IDLE with all outputs at reset values.
  - the interrupted access produces no ready pulse.
  - the interrupted access is not retried.
- mem_rdata is sampled only at the edge where the counter is 0 in ACCESS.

## Structure
- Shared package holds:
  - state encoding: IDLE=0, ACCESS=1, RESP=2 (2-bit).
  - requester IDs: REQ_CPU=0, REQ_LD=1.
  - WAIT_CYCLES default.
- Single module, no sub-module.
- Round-robin select is one inline expression on last_grant.
- Counter is 4 bits.

## Test plan
All tests use WAIT_CYCLES=2.
- CPU read: cpu_rd=1, cpu_addr=0x40, mem returns 0xDEADBEEF -> mem_en high cycles 1-2; cpu_ready pulses cycle 3; cpu_rdata=0xDEADBEEF; ld_ready stays 0.
- Loader write: ld_req=1, ld_we=1, ld_addr=0x10, ld_wdata=0x1234 -> mem_we=1 with addr 0x10 and data 0x1234 for 2 cycles; ld_ready pulses once; ld_rdata unchanged.
- Simultaneous requests after reset, both held -> CPU served first, loader second, CPU third; ready pulses at cycles 3, 7, 11.
- cpu_rd=cpu_wr=1 at 0x20 with wdata 0x5 -> treated as write: mem_we=1 throughout ACCESS.
- Reset asserted in the first ACCESS cycle -> next cycle mem_en=0 and busy=0; no ready pulse; rdata registers = 0.
- Request dropped mid-ACCESS -> access completes and the ready pulse still occurs.
